// File: rtl/seq_mult_pkg.sv
//------------------------------------------------------------------------------
// Module   : seq_mult_pkg
// Purpose  : State encoding and sizing helpers shared by the shift-add multiplier.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package seq_mult_pkg;

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_RUN  = 1'b1;

   // The counter must hold the terminal value WIDTH itself, not just WIDTH-1.
   function automatic int cnt_width(input int w);
      return $clog2(w + 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/seq_mult.sv
//------------------------------------------------------------------------------
// Module   : seq_mult
// Purpose  : Sequential shift-add multiplier, signed/unsigned, one partial product per clock.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module seq_mult
   import seq_mult_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               is_signed,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] p
);

   localparam int             CW     = cnt_width(WIDTH);
   localparam logic [CW-1:0]  c_last = CW'(WIDTH - 1);

   // Magnitude of the most-negative value is representable as an unsigned WIDTH-bit number.
   function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic sgn);
      return (sgn && x[WIDTH-1]) ? (~x + {{(WIDTH-1){1'b0}}, 1'b1}) : x;
   endfunction

   logic [0:0]         r_state;
   logic [CW-1:0]      r_cnt;
   logic [WIDTH-1:0]   r_mcand;
   logic [WIDTH-1:0]   r_mplier;
   logic [2*WIDTH-1:0] r_acc;
   logic               r_neg;
   logic               r_done;
   logic [2*WIDTH-1:0] r_p;

   logic [WIDTH-1:0]   w_addend;
   logic [WIDTH:0]     w_sum;
   logic [2*WIDTH-1:0] w_acc_next;
   logic [2*WIDTH-1:0] w_result;

   assign w_addend   = r_mplier[0] ? r_mcand : '0;
   assign w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, w_addend};
   // Carry-out lands in the top bit; the low half absorbs bits shifted out of the high half.
   assign w_acc_next = {w_sum, r_acc[WIDTH-1:1]};
   assign w_result   = r_neg ? (~w_acc_next + {{(2*WIDTH-1){1'b0}}, 1'b1}) : w_acc_next;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_acc    <= '0;
         r_neg    <= 1'b0;
         r_done   <= 1'b0;
         r_p      <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_mcand  <= mag(a, is_signed);
                  r_mplier <= mag(b, is_signed);
                  r_neg    <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                  r_acc    <= '0;
                  r_cnt    <= '0;
                  r_state  <= S_RUN;
               end
            end
            S_RUN: begin
               r_acc    <= w_acc_next;
               r_mplier <= r_mplier >> 1;
               r_cnt    <= r_cnt + 1'b1;
               if (r_cnt == c_last) begin
                  r_p     <= w_result;
                  r_done  <= 1'b1;
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign busy = (r_state == S_RUN);
   assign done = r_done;
   assign p    = r_p;

endmodule

`default_nettype wire

// File: tb/tb_seq_mult.sv
//------------------------------------------------------------------------------
// Module   : tb_seq_mult
// Purpose  : Directed self-checking bench for seq_mult at WIDTH=4 and WIDTH=8.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_seq_mult;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start4 = 1'b0, sgn4 = 1'b0;
   logic [3:0]  a4 = '0, b4 = '0;
   logic        busy4, done4;
   logic [7:0]  p4;
   logic        start8 = 1'b0, sgn8 = 1'b0;
   logic [7:0]  a8 = '0, b8 = '0;
   logic        busy8, done8;
   logic [15:0] p8;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   seq_mult #(.WIDTH(4)) u_dut4 (
      .clk(clk), .rst(rst), .start(start4), .is_signed(sgn4),
      .a(a4), .b(b4), .busy(busy4), .done(done4), .p(p4)
   );

   seq_mult #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst(rst), .start(start8), .is_signed(sgn8),
      .a(a8), .b(b8), .busy(busy8), .done(done8), .p(p8)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drives one start cycle, then waits (bounded) for done; lat counts edges after the start edge.
   task automatic op(input bit w8, input logic sg, input logic [7:0] av, input logic [7:0] bv,
                     output int lat, output int bc);
      if (w8) begin start8 = 1'b1; sgn8 = sg; a8 = av; b8 = bv; end
      else    begin start4 = 1'b1; sgn4 = sg; a4 = av[3:0]; b4 = bv[3:0]; end
      @(posedge clk); #1;
      start4 = 1'b0; start8 = 1'b0;
      bc  = (w8 ? busy8 : busy4) ? 1 : 0;
      lat = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         lat++;
         if (w8 ? done8 : done4) break;
         if (w8 ? busy8 : busy4) bc++;
      end
   endtask

   int lat, bc, ndone;
   logic [7:0] p_seen;

   initial begin
      #12;
      chk("rst_p4", 32'(p4), 32'h0);
      chk("rst_busy4", 32'(busy4), 32'h0);
      chk("rst_done4", 32'(done4), 32'h0);
      chk("rst_p8", 32'(p8), 32'h0);
      chk("rst_busy8", 32'(busy8), 32'h0);
      chk("rst_done8", 32'(done8), 32'h0);
      @(negedge clk) rst = 1'b1;
      @(negedge clk);

      op(1'b0, 1'b0, 8'hA, 8'hA, lat, bc);
      chk("u10x10_p", 32'(p4), 32'd100);
      chk("u10x10_lat", 32'(lat), 32'd4);
      chk("u10x10_busy_cycles", 32'(bc), 32'd4);
      chk("u10x10_not_busy_at_done", 32'(busy4), 32'h0);

      op(1'b0, 1'b0, 8'd6, 8'd14, lat, bc);
      chk("b2b_6x14_p", 32'(p4), 32'd84);
      chk("b2b_6x14_lat", 32'(lat), 32'd4);
      chk("b2b_done_overlap", 32'(done4), 32'h1);
      op(1'b0, 1'b0, 8'd9, 8'd12, lat, bc);
      chk("b2b_9x12_p", 32'(p4), 32'd108);
      chk("b2b_9x12_lat", 32'(lat), 32'd4);
      op(1'b0, 1'b0, 8'd10, 8'd1, lat, bc);
      chk("b2b_10x1_p", 32'(p4), 32'd10);
      chk("b2b_10x1_lat", 32'(lat), 32'd4);

      op(1'b0, 1'b1, 8'h9, 8'h6, lat, bc);
      chk("s_m7x6_p", 32'(p4), 32'hD6);
      op(1'b0, 1'b1, 8'h8, 8'h8, lat, bc);
      chk("s_m8xm8_p", 32'(p4), 32'h40);
      op(1'b0, 1'b1, 8'hF, 8'hF, lat, bc);
      chk("s_m1xm1_p", 32'(p4), 32'h01);
      op(1'b0, 1'b0, 8'hF, 8'hF, lat, bc);
      chk("u15x15_p", 32'(p4), 32'hE1);
      op(1'b0, 1'b0, 8'h0, 8'hB, lat, bc);
      chk("u0x11_p", 32'(p4), 32'h00);
      chk("u0x11_lat", 32'(lat), 32'd4);

      // start during RUN must not disturb the operation in flight
      @(negedge clk);
      start4 = 1'b1; sgn4 = 1'b0; a4 = 4'd3; b4 = 4'd5;
      @(posedge clk); #1; start4 = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      start4 = 1'b1; a4 = 4'd7; b4 = 4'd7; sgn4 = 1'b1;
      @(posedge clk); #1; start4 = 1'b0;
      chk("ign_busy", 32'(busy4), 32'h1);
      ndone = 0; p_seen = '0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (done4) begin ndone++; p_seen = p4; end
      end
      chk("ign_p", 32'(p_seen), 32'd15);
      chk("ign_done_count", 32'(ndone), 32'd1);

      // asynchronous abort mid-operation
      @(negedge clk);
      start4 = 1'b1; sgn4 = 1'b0; a4 = 4'd5; b4 = 4'd5;
      @(posedge clk); #1; start4 = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      #2 rst = 1'b0;
      #1;
      chk("abort_p", 32'(p4), 32'h0);
      chk("abort_busy", 32'(busy4), 32'h0);
      chk("abort_done", 32'(done4), 32'h0);
      @(negedge clk) rst = 1'b1;
      ndone = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (done4 || busy4) ndone++;
      end
      chk("abort_quiet", 32'(ndone), 32'd0);

      @(negedge clk);
      op(1'b1, 1'b0, 8'hFF, 8'hFF, lat, bc);
      chk("w8_u255x255_p", 32'(p8), 32'd65025);
      chk("w8_u255x255_lat", 32'(lat), 32'd8);
      chk("w8_busy_cycles", 32'(bc), 32'd8);
      op(1'b1, 1'b1, 8'h80, 8'h7F, lat, bc);
      chk("w8_s_m128x127_p", 32'(p8), 32'hC080);
      chk("w8_s_m128x127_lat", 32'(lat), 32'd8);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
